// File: rtl/alu_pipe_mdu.sv
// alu_pipe_mdu: registered execute-stage ALU with valid/ready handshakes on both sides.
// Define ALU_MDU_EN to add the iterative multiply/divide unit (opcodes 01111-10010).
module alu_pipe_mdu #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   arg1,
   input  logic [WIDTH-1:0]   arg2,
   input  logic [4:0]         alu_op,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   result,
   output logic               zero
);
   localparam int SW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, next_state;

   logic             accept;
   logic             start_mdu;
   logic             mdu_last;
   logic [SW-1:0]    sh;
   logic [WIDTH-1:0] alu_value;
   logic [WIDTH-1:0] mem_sum;

   // Shift amounts wrap modulo WIDTH, which the cast provides since WIDTH is a power of 2.
   assign sh      = SW'(shamt);
   assign mem_sum = arg1 + arg2;
   assign accept  = in_valid && in_ready && !flush;

   always_comb begin
      alu_value = '0;
      case (alu_op)
         5'b00000: alu_value = arg1 + arg2;
         5'b00001: alu_value = arg1 - arg2;
         5'b00010: alu_value = arg1 & arg2;
         5'b00011: alu_value = arg1 | arg2;
         5'b00100: alu_value = ~(arg1 | arg2);
         5'b00101: alu_value = arg2 << sh;
         5'b00110: alu_value = arg2 >> sh;
         5'b00111: alu_value = $signed(arg2) >>> sh;
         5'b01000: alu_value = {{(WIDTH-1){1'b0}}, $signed(arg1) < $signed(arg2)};
         5'b01001: alu_value = arg2 << 16;
         5'b01010: alu_value = {{(WIDTH-1){1'b0}}, arg1 != arg2};
         5'b01011: alu_value = {{(WIDTH-1){1'b0}}, !arg1[WIDTH-1] && (|arg1)};
         5'b01100: alu_value = {{(WIDTH-1){1'b0}}, !arg1[WIDTH-1]};
         5'b01101: alu_value = {{(WIDTH-1){1'b0}}, arg1 == arg2};
         5'b01110: alu_value = mem_sum >> 2;
         default:  alu_value = '0;
      endcase
   end

`ifdef ALU_MDU_EN
   logic [WIDTH-1:0] acc, mq, mcand;
   logic [WIDTH-1:0] acc_next, mq_next, mdu_value;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [4:0]       mdu_op;
   logic [SW-1:0]    count;
   logic             is_div;

   assign start_mdu = (alu_op >= 5'b01111) && (alu_op <= 5'b10010);
   assign is_div    = (mdu_op == 5'b10001) || (mdu_op == 5'b10010);
   assign mdu_last  = &count;
   assign mul_sum   = {1'b0, acc} + {1'b0, mcand};
   assign div_shift = {acc, mq[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, mcand};
   assign mdu_value = ((mdu_op == 5'b01111) || (mdu_op == 5'b10001)) ? mq_next : acc_next;

   // acc holds the product high half / partial remainder; mq the product low half / quotient.
   // A zero divisor never borrows, giving an all-ones quotient and remainder = dividend.
   always_comb begin
      acc_next = acc;
      mq_next  = mq;
      if (is_div) begin
         if (!div_diff[WIDTH]) begin
            acc_next = div_diff[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], 1'b1};
         end else begin
            acc_next = div_shift[WIDTH-1:0];
            mq_next  = {mq[WIDTH-2:0], 1'b0};
         end
      end else if (mq[0]) begin
         {acc_next, mq_next} = {mul_sum, mq[WIDTH-1:1]};
      end else begin
         {acc_next, mq_next} = {1'b0, acc, mq[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         mq     <= '0;
         mcand  <= '0;
         mdu_op <= '0;
         count  <= '0;
      end else if (accept && start_mdu) begin
         acc    <= '0;
         mq     <= arg1;
         mcand  <= arg2;
         mdu_op <= alu_op;
         count  <= '0;
      end else if (state == BUSY && !flush) begin
         acc   <= acc_next;
         mq    <= mq_next;
         count <= count + SW'(1);
      end
   end
`else
   assign start_mdu = 1'b0;
   assign mdu_last  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // In DONE the unit takes a new op in the same cycle the current result is accepted.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = start_mdu ? BUSY : DONE;
         end
         BUSY: if (mdu_last) next_state = DONE;
         DONE: begin
            in_ready = out_ready;
            if (out_ready) next_state = in_valid ? (start_mdu ? BUSY : DONE) : IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (flush) next_state = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
      end else begin
         out_valid <= (next_state == DONE);
         if (accept && !start_mdu) begin
            result <= alu_value;
            zero   <= (alu_value == '0);
         end
`ifdef ALU_MDU_EN
         else if (state == BUSY && !flush && mdu_last) begin
            result <= mdu_value;
            zero   <= (mdu_value == '0);
         end
`endif
      end
   end
endmodule

// File: tb/tb_alu_pipe_mdu.sv
// tb_alu_pipe_mdu: directed vectors checked by a queue scoreboard and a separate output monitor.
// MDU expectations follow ALU_MDU_EN, matching the build of the design.
module tb_alu_pipe_mdu;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, zero;
   logic [31:0] arg1 = '0, arg2 = '0, result;
   logic [4:0]  alu_op = '0, shamt = '0;
   int          total = 0, bad = 0, cycle = 0;
   logic        saw_valid;

   typedef struct {logic [31:0] res; logic z; int acc_cycle; int lat;} exp_t;
   typedef struct {logic [4:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] sh; logic [31:0] r; logic z;} vec_t;
   exp_t sb[$];
   vec_t vecs[$];

   alu_pipe_mdu #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .arg1(arg1), .arg2(arg2), .alu_op(alu_op), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Inputs change 1 time unit after a rising edge; handshakes are observed on the falling edge.
   task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [31:0] r, input logic z,
                                input int lat, input bit push);
      int waited = 0;
      alu_op = op; arg1 = a; arg2 = b; shamt = sh; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         total++; bad++;
         $display("[TB] FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 100 cycles");
      end else if (push) begin
         sb.push_back('{r, z, cycle, lat});
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++; bad++;
               $display("[TB] FAIL unexpected_output: got 0x%08h expected no output", result);
            end else begin
               e = sb.pop_front();
               checkOutput("result", result, e.res);
               checkOutput("zero", 32'(zero), 32'(e.z));
               if (e.lat != 0) checkOutput("latency", 32'(cycle - e.acc_cycle), 32'(e.lat));
            end
         end
      end
   end

   initial begin
      vecs.push_back('{5'b01101, 32'd4, 32'd4, 5'd0, 32'd1, 1'b0});
      vecs.push_back('{5'b01011, 32'd0, 32'd9, 5'd0, 32'd0, 1'b1});
      vecs.push_back('{5'b01100, 32'd0, 32'd9, 5'd0, 32'd1, 1'b0});
      vecs.push_back('{5'b01110, 32'h100, 32'h8, 5'd0, 32'h42, 1'b0});
      vecs.push_back('{5'b01110, 32'hFFFF_FFFC, 32'h8, 5'd0, 32'h1, 1'b0});
      vecs.push_back('{5'b01010, 32'd4, 32'd5, 5'd0, 32'd1, 1'b0});
      vecs.push_back('{5'b01011, 32'h8000_0000, 32'd0, 5'd0, 32'd0, 1'b1});
      vecs.push_back('{5'b01100, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0, 1'b1});
      vecs.push_back('{5'b01001, 32'd0, 32'h1234, 5'd0, 32'h1234_0000, 1'b0});
      vecs.push_back('{5'b00100, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0});
      vecs.push_back('{5'b00010, 32'hF0F0, 32'h0FF0, 5'd0, 32'h00F0, 1'b0});
      vecs.push_back('{5'b00011, 32'hF000, 32'h000F, 5'd0, 32'hF00F, 1'b0});
      vecs.push_back('{5'b00101, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0});
      vecs.push_back('{5'b00110, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0});
      vecs.push_back('{5'b01000, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1});
      vecs.push_back('{5'b00000, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1});
      vecs.push_back('{5'b11111, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1});

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_result", result, 32'd0);
      checkOutput("rst_zero", 32'(zero), 32'd1);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      applyStimulus(5'b00000, 32'd5, 32'd3, 5'd0, 32'd8, 1'b0, 1, 1'b1);
      applyStimulus(5'b00001, 32'd3, 32'd3, 5'd0, 32'd0, 1'b1, 1, 1'b1);
      applyStimulus(5'b00111, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1, 1'b1);
      drain();

      out_ready = 1'b0;
      applyStimulus(5'b01000, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 0, 1'b1);
      alu_op = 5'b00000; arg1 = 32'd1; arg2 = 32'd1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_result", result, 32'd1);
         checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      applyStimulus(5'b00000, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 1, 1'b1);
      drain();

      foreach (vecs[i])
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].r, vecs[i].z, 1, 1'b1);
      drain();

`ifdef ALU_MDU_EN
      applyStimulus(5'b01111, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'hFFFF_FFFE, 1'b0, 33, 1'b1);
      applyStimulus(5'b10000, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd1, 1'b0, 33, 1'b1);
      applyStimulus(5'b10001, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 33, 1'b1);
      applyStimulus(5'b10010, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, 33, 1'b1);
      applyStimulus(5'b10001, 32'd9, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 33, 1'b1);
      applyStimulus(5'b10010, 32'd9, 32'd0, 5'd0, 32'd9, 1'b0, 33, 1'b1);
`else
      applyStimulus(5'b01111, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd0, 1'b1, 1, 1'b1);
      applyStimulus(5'b10000, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'd0, 1'b1, 1, 1'b1);
      applyStimulus(5'b10001, 32'd100, 32'd7, 5'd0, 32'd0, 1'b1, 1, 1'b1);
      applyStimulus(5'b10010, 32'd100, 32'd7, 5'd0, 32'd0, 1'b1, 1, 1'b1);
`endif
      drain();

      alu_op = 5'b00000; arg1 = 32'd1; arg2 = 32'd1; flush = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      checkOutput("flush_beats_in_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

`ifdef ALU_MDU_EN
      applyStimulus(5'b10001, 32'd100, 32'd7, 5'd0, 32'd0, 1'b0, 0, 1'b0);
      repeat (5) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checkOutput("flush_busy_in_ready", 32'(in_ready), 32'd1);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      checkOutput("flush_busy_no_valid", 32'(saw_valid), 32'd0);
      @(posedge clk); #1;
      applyStimulus(5'b10001, 32'd100, 32'd7, 5'd0, 32'd0, 1'b0, 0, 1'b0);
      repeat (9) @(posedge clk);
`else
      out_ready = 1'b0;
      applyStimulus(5'b00000, 32'd5, 32'd3, 5'd0, 32'd0, 1'b0, 0, 1'b0);
      repeat (2) @(posedge clk);
`endif
      #3 rst = 1'b1;
      #1;
      checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_result", result, 32'd0);
      checkOutput("midrst_zero", 32'(zero), 32'd1);
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(posedge clk);
      checkOutput("post_rst_idle_valid", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
